// File: rtl/gauss_seq_ctrl.sv
// gauss_seq_ctrl
//
// Sequencer for the Gaussian noise peripheral. It watches the peripheral
// control register. On a software start request it produces a programmed
// number of approximately Gaussian samples and writes them to the sample
// memory. Each sample is the sum of 12 uniform 12-bit values taken from a
// 16-bit Galois LFSR, which is a central-limit approximation. The sum is
// centred on zero before it is stored. When the run is complete, the block
// writes the control register back with done set and start cleared.
//
// Control register layout: bit 0 start, bit 1 done, [15:8] sample count
// (0 means 256), [31:16] seed.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous, active-high reset
//   ctrl_in    in   current control register value
//   ctrl_out   out  write-back value for the control register
//   ctrl_we    out  one-cycle strobe that writes ctrl_out into the register
//   mem_addr   out  sample memory write address (BASE_ADDR + index, wraps)
//   mem_wdata  out  signed sample, range -24570..+24570
//   mem_we     out  one-cycle sample memory write strobe
//   busy       out  high whenever the sequencer is not idle
//
// All outputs are registered.

module gauss_seq_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ctrl_in,
    output logic [31:0]       ctrl_out,
    output logic              ctrl_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              busy
);

    localparam logic [15:0]       LFSR_MASK   = 16'hB400;
    localparam logic [15:0]       SEED_SUBST  = 16'hACE1;
    localparam logic [3:0]        LAST_STEP   = 4'd11;
    localparam logic [ADDR_W-1:0] BASE        = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_ACC,
        S_STORE,
        S_DONE
    } state_t;

    // One Galois step: right shift, then XOR in the tap mask when a 1 falls out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // The mean of 12 uniform 0..4095 values is 12*4095/2 = 24570.
    // Subtracting it makes the sum zero-mean.
    function automatic logic signed [31:0] center_sample(input logic [15:0] acc);
        return $signed({16'h0000, acc}) - 32'sd24570;
    endfunction

    state_t            state_q;
    logic [15:0]       seed_q;
    logic [7:0]        cnt_q;
    logic [7:0]        idx_q;
    logic [15:0]       lfsr_q;
    logic [15:0]       acc_q;
    logic [3:0]        step_q;

    logic [31:0]       ctrl_out_q;
    logic              ctrl_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              mem_we_q;
    logic              busy_q;

    logic [15:0]       lfsr_d;
    logic [15:0]       acc_d;
    logic [ADDR_W-1:0] addr_d;
    logic [15:0]       seed_eff;
    logic              trigger;
    logic              last_sample;
    logic              unused_ctrl_bits;

    // Datapath next values used by the FSM.
    assign lfsr_d      = lfsr_step(lfsr_q);
    assign acc_d       = acc_q + {4'h0, lfsr_d[11:0]};
    assign addr_d      = BASE + ADDR_W'(idx_q);
    // A zero seed would lock the LFSR at zero, so it is replaced.
    assign seed_eff    = (seed_q == 16'h0000) ? SEED_SUBST : seed_q;
    // The done bit has to be cleared before the next run can start.
    // This prevents a retrigger from a register value that still holds start.
    assign trigger     = ctrl_in[0] && !ctrl_in[1];
    // The count wraps in 8 bits, so a count field of 0 ends at idx 255.
    assign last_sample = (idx_q == (cnt_q - 8'd1));
    assign unused_ctrl_bits = ^ctrl_in[7:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            seed_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            lfsr_q      <= '0;
            acc_q       <= '0;
            step_q      <= '0;
            ctrl_out_q  <= '0;
            ctrl_we_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        cnt_q   <= ctrl_in[15:8];
                        seed_q  <= ctrl_in[31:16];
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SEED;
                    end
                end

                S_SEED: begin
                    lfsr_q  <= seed_eff;
                    acc_q   <= '0;
                    step_q  <= '0;
                    state_q <= S_ACC;
                end

                S_ACC: begin
                    lfsr_q <= lfsr_d;
                    acc_q  <= acc_d;
                    if (step_q == LAST_STEP) begin
                        // Register the store outputs here so that the
                        // write strobe lines up with the STORE state.
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= center_sample(acc_d);
                        state_q     <= S_STORE;
                    end else begin
                        step_q <= step_q + 4'd1;
                    end
                end

                S_STORE: begin
                    mem_we_q <= 1'b0;
                    if (last_sample) begin
                        // Write back the original seed and count, set done
                        // and clear start.
                        ctrl_we_q  <= 1'b1;
                        ctrl_out_q <= {seed_q, cnt_q, 6'b000000, 1'b1, 1'b0};
                        state_q    <= S_DONE;
                    end else begin
                        // The LFSR keeps running into the next sample.
                        idx_q   <= idx_q + 8'd1;
                        acc_q   <= '0;
                        step_q  <= '0;
                        state_q <= S_ACC;
                    end
                end

                S_DONE: begin
                    ctrl_we_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ctrl_out  = ctrl_out_q;
    assign ctrl_we   = ctrl_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gauss_seq_ctrl.sv
// Directed bench for gauss_seq_ctrl. It uses three instances with
// BASE_ADDR 0x00, 0xF0 and 0x10. A small LFSR/sum model produces the
// expected sample values.
module tb_gauss_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ctrl_in   [3];
    logic [31:0] ctrl_out  [3];
    logic        ctrl_we   [3];
    logic [7:0]  mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic        mem_we    [3];
    logic        busy      [3];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    gauss_seq_ctrl #(.ADDR_W(8), .BASE_ADDR(8'h00)) u_dut0 (
        .clk(clk), .rst(rst), .ctrl_in(ctrl_in[0]), .ctrl_out(ctrl_out[0]),
        .ctrl_we(ctrl_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_we(mem_we[0]), .busy(busy[0]));

    gauss_seq_ctrl #(.ADDR_W(8), .BASE_ADDR(8'hF0)) u_dut1 (
        .clk(clk), .rst(rst), .ctrl_in(ctrl_in[1]), .ctrl_out(ctrl_out[1]),
        .ctrl_we(ctrl_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_we(mem_we[1]), .busy(busy[1]));

    gauss_seq_ctrl #(.ADDR_W(8), .BASE_ADDR(8'h10)) u_dut2 (
        .clk(clk), .rst(rst), .ctrl_in(ctrl_in[2]), .ctrl_out(ctrl_out[2]),
        .ctrl_we(ctrl_we[2]), .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]),
        .mem_we(mem_we[2]), .busy(busy[2]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // Runs one job on instance d. It checks the timing of every strobe, each
    // write address and data value, the write-back value and the busy length.
    // The control register write is emulated by copying ctrl_out into ctrl_in.
    task automatic run_dut(input int d, input logic [31:0] cin, input logic [7:0] base,
                           input logic [31:0] exp_ctrl, input int exp_busy,
                           output logic [31:0] last_data, output logic [7:0] last_addr);
        int          n;
        int          k;
        int          c;
        int          busy_cyc;
        int          ctrl_cnt;
        bit          fin;
        logic [15:0] s;
        logic [15:0] a;
        logic [31:0] expd [256];
        logic [7:0]  ea;
        int          sd;

        n = (cin[15:8] == 8'd0) ? 256 : int'(cin[15:8]);
        s = (cin[31:16] == 16'h0000) ? 16'hACE1 : cin[31:16];
        for (int i = 0; i < n; i++) begin
            a = 16'h0000;
            for (int j = 0; j < 12; j++) begin
                s = model_step(s);
                a = a + {4'h0, s[11:0]};
            end
            expd[i] = 32'(int'(a) - 24570);
        end

        k = 0; c = 0; busy_cyc = 0; ctrl_cnt = 0; fin = 0;
        last_data = '0; last_addr = '0;
        @(negedge clk);
        ctrl_in[d] = cin;
        while (!fin) begin
            @(negedge clk);
            c++;
            if (busy[d]) busy_cyc++;
            if (mem_we[d]) begin
                if (k < n) begin
                    ea = base + 8'(k);
                    chk("we_cycle", 32'(c), 32'(14 + 13 * k));
                    chk("mem_addr", {24'h0, mem_addr[d]}, {24'h0, ea});
                    chk("mem_wdata", mem_wdata[d], expd[k]);
                    sd = $signed(mem_wdata[d]);
                    chk("range", {31'h0, (sd >= -24570 && sd <= 24570)}, 32'd1);
                end
                last_data = mem_wdata[d];
                last_addr = mem_addr[d];
                k++;
            end
            if (ctrl_we[d]) begin
                ctrl_cnt++;
                chk("ctrl_we_cycle", 32'(c), 32'(exp_busy));
                chk("ctrl_out", ctrl_out[d], exp_ctrl);
                ctrl_in[d] = ctrl_out[d];
            end
            if (c > 2 && !busy[d]) fin = 1;
            if (c > exp_busy + 30) begin
                chk("run_timeout", 32'd0, 32'd1);
                fin = 1;
            end
        end
        chk("num_writes", 32'(k), 32'(n));
        chk("ctrl_we_count", 32'(ctrl_cnt), 32'd1);
        chk("busy_cycles", 32'(busy_cyc), 32'(exp_busy));
    endtask

    initial begin : stim
        logic [31:0] ld;
        logic [31:0] ld_ace;
        logic [7:0]  la;
        logic        any;
        logic [31:0] orv;
        logic [15:0] rs;
        int          c;

        for (int i = 0; i < 3; i++) ctrl_in[i] = 32'h0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;

        // Reset values, then 20 idle cycles with no activity.
        @(negedge clk);
        chk("rst_ctrl_out", ctrl_out[0], 32'h0);
        chk("rst_ctrl_we", {31'h0, ctrl_we[0]}, 32'h0);
        chk("rst_mem_addr", {24'h0, mem_addr[0]}, 32'h0);
        chk("rst_mem_wdata", mem_wdata[0], 32'h0);
        chk("rst_mem_we", {31'h0, mem_we[0]}, 32'h0);
        chk("rst_busy", {31'h0, busy[0]}, 32'h0);
        any = 1'b0; orv = 32'h0;
        repeat (20) begin
            @(negedge clk);
            any = any | busy[0] | mem_we[0] | ctrl_we[0];
            orv = orv | ctrl_out[0] | mem_wdata[0] | {24'h0, mem_addr[0]};
        end
        chk("idle_strobes", {31'h0, any}, 32'h0);
        chk("idle_outputs", orv, 32'h0);

        // Seed 0x1234, count 3.
        run_dut(0, 32'h1234_0301, 8'h00, 32'h1234_0302, 41, ld, la);
        chk("cnt3_last_addr", {24'h0, la}, 32'h02);

        // Start and done both still set: the block must stay idle.
        @(negedge clk);
        ctrl_in[0] = 32'h1234_0303;
        any = 1'b0;
        repeat (30) begin
            @(negedge clk);
            any = any | busy[0] | mem_we[0] | ctrl_we[0];
        end
        chk("no_retrigger", {31'h0, any}, 32'h0);
        run_dut(0, 32'h1234_0301, 8'h00, 32'h1234_0302, 41, ld, la);

        // Zero seed must give the same samples as seed 0xACE1.
        run_dut(1, 32'h0000_0101, 8'hF0, 32'h0000_0102, 15, ld, la);
        chk("seed0_addr", {24'h0, la}, 32'hF0);
        run_dut(1, 32'hACE1_0101, 8'hF0, 32'hACE1_0102, 15, ld_ace, la);
        chk("seed0_eq_ace1", ld, ld_ace);

        // Count field 0: 256 samples, and the address wraps.
        run_dut(2, 32'h5A5A_0001, 8'h10, 32'h5A5A_0002, 3330, ld, la);
        chk("cnt256_last_addr", {24'h0, la}, 32'h0F);

        // Reset during the third ACC cycle of sample 1.
        @(negedge clk);
        ctrl_in[0] = 32'h1234_0301;
        c = 0;
        while (c < 17) begin
            @(negedge clk);
            c++;
            if (c == 14) chk("pre_rst_store", {31'h0, mem_we[0]}, 32'd1);
        end
        rst = 1'b1;
        ctrl_in[0] = 32'h0;
        @(negedge clk);
        chk("midrst_ctrl_out", ctrl_out[0], 32'h0);
        chk("midrst_ctrl_we", {31'h0, ctrl_we[0]}, 32'h0);
        chk("midrst_mem_addr", {24'h0, mem_addr[0]}, 32'h0);
        chk("midrst_mem_wdata", mem_wdata[0], 32'h0);
        chk("midrst_mem_we", {31'h0, mem_we[0]}, 32'h0);
        chk("midrst_busy", {31'h0, busy[0]}, 32'h0);
        rst = 1'b0;
        any = 1'b0;
        repeat (40) begin
            @(negedge clk);
            any = any | busy[0] | mem_we[0] | ctrl_we[0];
        end
        chk("post_rst_quiet", {31'h0, any}, 32'h0);
        run_dut(0, 32'h1234_0301, 8'h00, 32'h1234_0302, 41, ld, la);

        // Long runs with random seeds.
        for (int r = 0; r < 12; r++) begin
            rs = 16'($urandom);
            run_dut(2, {rs, 8'h00, 8'h01}, 8'h10, {rs, 8'h00, 8'h02}, 3330, ld, la);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
